// File: rtl/full_adder.sv
// One-bit full adder with a combinational path and a registered bit-serial path
// whose carry can be chained across clocks to add multi-bit words LSB first.
module full_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic ser_en,
  input  logic ser_clr,
  output logic S,
  output logic Cout,
  output logic S_q,
  output logic Cout_q
);

  logic c_sel;
  logic carry_q;

  function automatic logic sum_bit(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic maj_bit(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign S    = sum_bit(A, B, Cin);
  assign Cout = maj_bit(A, B, Cin);

  // ser_clr starts a new word and overrides chaining from the carry register.
  always_comb begin
    c_sel = Cin;
    if (ser_clr)
      c_sel = 1'b0;
    else if (ser_en)
      c_sel = carry_q;
  end

  // ---- stage p0 -> registered serial outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      S_q     <= sum_bit(A, B, c_sel);
      carry_q <= maj_bit(A, B, c_sel);
    end
  end

  assign Cout_q = carry_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: truth-table vectors, serial word sequences, reset
// corner cases and randomized cycles against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n, A, B, Cin, ser_en, ser_clr;
  logic S, Cout, S_q, Cout_q;

  int n_vec = 0;
  int n_err = 0;

  full_adder dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin),
    .ser_en(ser_en), .ser_clr(ser_clr),
    .S(S), .Cout(Cout), .S_q(S_q), .Cout_q(Cout_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a, b, cin;
    logic s, cout;
  } vec_t;

  vec_t tt [8];

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  // Adds two 4-bit words serially; expected bits come from ordinary integer addition.
  task automatic serial_word(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < 4; i++) begin
      A = a[i]; B = b[i]; Cin = 1'($urandom);
      ser_en = 1'b1; ser_clr = (i == 0);
      #1;
      chk("ser_comb_S", S, 1'((int'(A) + int'(B) + int'(Cin)) % 2));
      edge_settle();
      chk($sformatf("ser_S_q_bit%0d", i), S_q, sum[i]);
    end
    chk("ser_final_carry", Cout_q, sum[4]);
  endtask

  initial begin
    int tot, ref_c, cin_sel;
    logic exp_s, exp_c;

    tt[0] = '{0,0,0, 0,0}; tt[1] = '{1,0,0, 1,0};
    tt[2] = '{0,1,0, 1,0}; tt[3] = '{1,1,0, 0,1};
    tt[4] = '{0,0,1, 1,0}; tt[5] = '{1,0,1, 0,1};
    tt[6] = '{0,1,1, 0,1}; tt[7] = '{1,1,1, 1,1};

    rst_n = 1'b0; A = 0; B = 0; Cin = 0; ser_en = 0; ser_clr = 0;
    #1;
    chk("rst_S_q", S_q, 1'b0);
    chk("rst_Cout_q", Cout_q, 1'b0);

    // Combinational truth table, exercised while still in reset.
    for (int i = 0; i < 8; i++) begin
      A = tt[i].a; B = tt[i].b; Cin = tt[i].cin;
      #1;
      chk($sformatf("tt%0d_S", i), S, tt[i].s);
      chk($sformatf("tt%0d_Cout", i), Cout, tt[i].cout);
    end

    A = 1; B = 1; Cin = 1;
    edge_settle();
    edge_settle();
    chk("rst_hold_S_q", S_q, 1'b0);
    chk("rst_hold_Cout_q", Cout_q, 1'b0);

    #2 rst_n = 1'b1;
    edge_settle();
    chk("post_rst_S_q", S_q, 1'b1);
    chk("post_rst_Cout_q", Cout_q, 1'b1);

    serial_word(4'b0101, 4'b0011);
    serial_word(4'b1111, 4'b0001);
    A = 0; B = 0; ser_clr = 1; ser_en = 1; Cin = 1;
    edge_settle();
    chk("clr_S_q", S_q, 1'b0);
    chk("clr_Cout_q", Cout_q, 1'b0);
    serial_word(4'b1011, 4'b0110);

    // Pipelined-copy mode.
    ser_en = 0; ser_clr = 0; A = 1; B = 1; Cin = 1;
    #1;
    chk("pipe_S", S, 1'b1);
    chk("pipe_Cout", Cout, 1'b1);
    edge_settle();
    chk("pipe_S_q", S_q, 1'b1);
    chk("pipe_Cout_q", Cout_q, 1'b1);

    // Randomized cycles; the first cycle clears so the model carry is known.
    ref_c = 0;
    for (int k = 0; k < 300; k++) begin
      A = 1'($urandom); B = 1'($urandom); Cin = 1'($urandom);
      ser_en = 1'($urandom);
      ser_clr = (k == 0) || ($urandom_range(0, 5) == 0);
      cin_sel = ser_clr ? 0 : (ser_en ? ref_c : int'(Cin));
      tot = int'(A) + int'(B) + cin_sel;
      exp_s = 1'(tot % 2);
      exp_c = (tot >= 2);
      ref_c = tot / 2;
      #1;
      tot = int'(A) + int'(B) + int'(Cin);
      chk("rnd_S", S, 1'(tot % 2));
      chk("rnd_Cout", Cout, tot >= 2);
      edge_settle();
      chk("rnd_S_q", S_q, exp_s);
      chk("rnd_Cout_q", Cout_q, exp_c);
    end

    // Asynchronous reset mid-word with carry and sum set.
    ser_en = 0; ser_clr = 0; A = 1; B = 1; Cin = 1;
    edge_settle();
    chk("pre_rst_Cout_q", Cout_q, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_S_q", S_q, 1'b0);
    chk("async_rst_Cout_q", Cout_q, 1'b0);
    edge_settle();
    chk("rst_edge_S_q", S_q, 1'b0);
    chk("rst_edge_Cout_q", Cout_q, 1'b0);
    A = 1; B = 0; Cin = 1;
    #1;
    chk("rst_comb_S", S, 1'b0);
    chk("rst_comb_Cout", Cout, 1'b1);
    #2 rst_n = 1'b1;
    // Carry was discarded: chaining now sees carry 0.
    A = 1; B = 0; Cin = 1; ser_en = 1; ser_clr = 0;
    edge_settle();
    chk("after_rst_chain_S_q", S_q, 1'b1);
    chk("after_rst_chain_Cout_q", Cout_q, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
